imem_arbiter: RTL

Two-requester read arbiter for the single-port, 32-word instruction memory of the RISC-V practice core. It shares the memory between instruction fetch (port F) and the load/debug read path (port D). Fetch has fixed priority, lock support holds an owner across consecutive beats, and a starvation counter bounds D's wait. It sits between the fetch stage / load unit and the memory's `Addr_i` / `Read_en_i` / `Read_data_o` pins.

---
 rtl/imem_arbiter_if.sv | 42 ++++
 rtl/imem_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the two instruction-memory requesters, the arbiter and the memory pins.
// slave = arbiter side, master = requester/memory side.
interface imem_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          F_req_i;
  logic [AW-1:0] F_addr_i;
  logic          F_lock_i;
  logic          F_gnt_o;
  logic [DW-1:0] F_data_o;
  logic          F_valid_o;

  logic          D_req_i;
  logic [AW-1:0] D_addr_i;
  logic          D_lock_i;
  logic          D_gnt_o;
  logic [DW-1:0] D_data_o;
  logic          D_valid_o;

  logic [AW-1:0] Mem_addr_o;
  logic          Mem_read_en_o;
  logic [DW-1:0] Mem_read_data_i;

  modport slave (
    input  F_req_i, F_addr_i, F_lock_i,
    output F_gnt_o, F_data_o, F_valid_o,
    input  D_req_i, D_addr_i, D_lock_i,
    output D_gnt_o, D_data_o, D_valid_o,
    output Mem_addr_o, Mem_read_en_o,
    input  Mem_read_data_i
  );

  modport master (
    output F_req_i, F_addr_i, F_lock_i,
    input  F_gnt_o, F_data_o, F_valid_o,
    output D_req_i, D_addr_i, D_lock_i,
    input  D_gnt_o, D_data_o, D_valid_o,
    input  Mem_addr_o, Mem_read_en_o,
    output Mem_read_data_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Fetch-priority read arbiter for the single-port instruction memory, with owner lock
// and a starvation counter that bounds how long the load/debug port can be denied.
module imem_arbiter #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_F, OWN_D} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_next;
  logic          w_force;
  logic          w_f_gnt;
  logic          w_d_gnt;
  logic [AW-1:0] w_mem_addr;
  logic          r_pend;
  logic          r_tag;
  logic [DW-1:0] r_f_data;
  logic [DW-1:0] r_d_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    if (w_f_gnt && bus.F_lock_i)
      w_state_next = OWN_F;
    else if (w_d_gnt && bus.D_lock_i)
      w_state_next = OWN_D;

    w_wait_next = '0;
    if (bus.D_req_i && !w_d_gnt)
      w_wait_next = (r_wait_cnt == 4'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + 4'd1;
  end

  // Forced D grant is checked first so it can break an F lock.
  always_comb begin
    w_force    = (r_wait_cnt == 4'(MAX_WAIT)) && bus.D_req_i;
    w_f_gnt    = 1'b0;
    w_d_gnt    = 1'b0;
    if (!rst_i) begin
      if (w_force)
        w_d_gnt = 1'b1;
      else if (r_state == OWN_F && bus.F_req_i)
        w_f_gnt = 1'b1;
      else if (r_state == OWN_D && bus.D_req_i)
        w_d_gnt = 1'b1;
      else if (bus.F_req_i)
        w_f_gnt = 1'b1;
      else if (bus.D_req_i)
        w_d_gnt = 1'b1;
    end
    w_mem_addr = '0;
    if (w_f_gnt)
      w_mem_addr = bus.F_addr_i;
    else if (w_d_gnt)
      w_mem_addr = bus.D_addr_i;
  end

  // Memory data is valid by the edge ending the grant cycle, so it is captured there
  // and the tag steers the one-cycle valid pulse to the winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend   <= 1'b0;
      r_tag    <= 1'b0;
      r_f_data <= '0;
      r_d_data <= '0;
    end else begin
      r_pend <= w_f_gnt | w_d_gnt;
      r_tag  <= w_d_gnt;
      if (w_f_gnt)
        r_f_data <= bus.Mem_read_data_i;
      if (w_d_gnt)
        r_d_data <= bus.Mem_read_data_i;
    end
  end

  assign bus.F_gnt_o       = w_f_gnt;
  assign bus.D_gnt_o       = w_d_gnt;
  assign bus.Mem_read_en_o = w_f_gnt | w_d_gnt;
  assign bus.Mem_addr_o    = w_mem_addr;
  assign bus.F_data_o      = r_f_data;
  assign bus.D_data_o      = r_d_data;
  assign bus.F_valid_o     = r_pend & ~r_tag;
  assign bus.D_valid_o     = r_pend & r_tag;

endmodule
